// File: rtl/wt_fetch_ctrl.sv
// Weight ROM fetch sequencer: walks a word range two words per beat over dual ROM ports and
// streams kernel pairs to the conv MAC array through a 2-entry (head + skid) buffer.
module wt_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic                  wt_valid,
  input  logic                  wt_ready,
  output logic [DATA_WIDTH-1:0] wt_data_a,
  output logic [DATA_WIDTH-1:0] wt_data_b,
  output logic                  wt_b_vld,
  output logic                  wt_last,
  output logic                  busy,
  output logic                  done
);

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("DEPTH does not fit in ADDR_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t                  state, state_next;
  logic                    busy_d, done_d;
  logic [ADDR_WIDTH-1:0]   beats_left;
  logic                    odd;
  logic                    inflight, infl_last, infl_bvld;
  logic                    skid_vld, skid_bvld, skid_last;
  logic [DATA_WIDTH-1:0]   skid_a, skid_b;

  logic                    start_ok_c, pop_c, issue_c, last_issue_c, empty_next_c;
  logic [1:0]              occ_c;
  logic [ADDR_WIDTH:0]     words_rnd_c;
  logic [ADDR_WIDTH-1:0]   beats_init_c;

  assign start_ok_c   = start && (state == IDLE);
  assign pop_c        = wt_valid && wt_ready;
  assign occ_c        = 2'(wt_valid) + 2'(skid_vld) + 2'(inflight);
  // Credit check: a beat leaving this cycle frees a slot for the pair issued now.
  assign issue_c      = (state == FETCH) && ((occ_c < 2'd2) || ((occ_c == 2'd2) && pop_c));
  assign last_issue_c = (beats_left == ADDR_WIDTH'(1));
  assign empty_next_c = !inflight && !skid_vld && (!wt_valid || pop_c);
  assign words_rnd_c  = {1'b0, num_words} + (ADDR_WIDTH+1)'(1);
  assign beats_init_c = words_rnd_c[ADDR_WIDTH:1];

  // State register (busy/done registered from the next-state decode)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_words == '0) ? FIN : FETCH;
      FETCH:   if (issue_c && last_issue_c) state_next = DRAIN;
      DRAIN:   if (empty_next_c) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (start_ok_c || (state_next == FETCH) || (state_next == DRAIN)) busy_d = 1'b1;
    if (state_next == FIN) done_d = 1'b1;
  end

  // Address pointer: holds the pair presented to the ROM; it is consumed on an issue edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_a <= '0;
      rom_addr_b <= '0;
      beats_left <= '0;
      odd        <= 1'b0;
    end else if (start_ok_c && (num_words != '0)) begin
      rom_addr_a <= first_addr;
      rom_addr_b <= ((beats_init_c == ADDR_WIDTH'(1)) && num_words[0])
                    ? first_addr : first_addr + ADDR_WIDTH'(1);
      beats_left <= beats_init_c;
      odd        <= num_words[0];
    end else if (issue_c) begin
      beats_left <= beats_left - ADDR_WIDTH'(1);
      if (!last_issue_c) begin
        rom_addr_a <= rom_addr_a + ADDR_WIDTH'(2);
        rom_addr_b <= ((beats_left == ADDR_WIDTH'(2)) && odd)
                      ? rom_addr_a + ADDR_WIDTH'(2) : rom_addr_a + ADDR_WIDTH'(3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      infl_last <= 1'b0;
      infl_bvld <= 1'b0;
    end else begin
      inflight  <= issue_c;
      infl_last <= last_issue_c;
      infl_bvld <= !(last_issue_c && odd);
    end
  end

  // Head (output registers) refills from skid first, then straight from the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_valid  <= 1'b0;
      wt_data_a <= '0;
      wt_data_b <= '0;
      wt_b_vld  <= 1'b0;
      wt_last   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_a    <= '0;
      skid_b    <= '0;
      skid_bvld <= 1'b0;
      skid_last <= 1'b0;
    end else if (!wt_valid || pop_c) begin
      if (skid_vld) begin
        wt_valid  <= 1'b1;
        wt_data_a <= skid_a;
        wt_data_b <= skid_b;
        wt_b_vld  <= skid_bvld;
        wt_last   <= skid_last;
        skid_vld  <= inflight;
        if (inflight) begin
          skid_a    <= rom_q_a;
          skid_b    <= rom_q_b;
          skid_bvld <= infl_bvld;
          skid_last <= infl_last;
        end
      end else if (inflight) begin
        wt_valid  <= 1'b1;
        wt_data_a <= rom_q_a;
        wt_data_b <= rom_q_b;
        wt_b_vld  <= infl_bvld;
        wt_last   <= infl_last;
      end else begin
        wt_valid  <= 1'b0;
      end
    end else if (inflight) begin
      skid_vld  <= 1'b1;
      skid_a    <= rom_q_a;
      skid_b    <= rom_q_b;
      skid_bvld <= infl_bvld;
      skid_last <= infl_last;
    end
  end

endmodule

// File: tb/tb_wt_fetch_ctrl.sv
// Directed bench for wt_fetch_ctrl with a behavioural 1-cycle-latency dual-port ROM.
module tb_wt_fetch_ctrl;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 144;
  localparam int unsigned DEPTH = 76;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_q_a = '0;
  logic [DW-1:0] rom_q_b = '0;
  logic          wt_valid;
  logic          wt_ready = 1'b0;
  logic [DW-1:0] wt_data_a, wt_data_b;
  logic          wt_b_vld, wt_last, busy, done;

  logic [DW-1:0] mem [0:DEPTH-1];
  int checks = 0;
  int errors = 0;

  wt_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .num_words(num_words),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b), .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data_a(wt_data_a), .wt_data_b(wt_data_b),
    .wt_b_vld(wt_b_vld), .wt_last(wt_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q_a <= mem[rom_addr_a];
    rom_q_b <= mem[rom_addr_b];
  end

  function automatic logic [DW-1:0] word_of(input int i);
    logic [DW-1:0] w;
    for (int j = 0; j < 9; j++) w[16*j +: 16] = 16'(i * 9 + j + 1) ^ 16'hA500;
    return w;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Runs one range; restart_at>0 injects a second start pulse at that cycle.
  task automatic run_range(input int first, input int n, input bit rnd, input int restart_at);
    int beats = (n + 1) / 2;
    int got = 0, cyc = 1, first_v = -1, last_c = -1, done_c = -1;
    bit stalled = 1'b0, rdy;
    logic [DW-1:0] hold_a = '0, hold_b = '0;
    logic hold_bv = 1'b0, hold_l = 1'b0;
    @(negedge clk);
    first_addr = AW'(first); num_words = AW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 400 && done_c < 0) begin
      start = 1'b0;
      if (cyc == restart_at) begin
        first_addr = AW'(40); num_words = AW'(4); start = 1'b1;
      end
      if (stalled) begin
        check("stall_hold", {wt_valid, wt_b_vld, wt_last, wt_data_a, wt_data_b},
              {1'b1, hold_bv, hold_l, hold_a, hold_b});
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wt_ready = rdy;
      if (wt_valid) begin
        if (first_v < 0) first_v = cyc;
        if (rdy) begin
          if (got < beats) begin
            check("beat_a", wt_data_a, word_of(first + 2 * got));
            check("beat_b", wt_data_b,
                  word_of((got == beats - 1 && n % 2 == 1) ? first + 2 * got : first + 2 * got + 1));
            check("beat_bvld", wt_b_vld, !(got == beats - 1 && n % 2 == 1));
            check("beat_last", wt_last, got == beats - 1);
          end else begin
            check("extra_beat", got, beats - 1);
          end
          got++;
          last_c = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_a = wt_data_a; hold_b = wt_data_b; hold_bv = wt_b_vld; hold_l = wt_last;
        end
      end
      if (done) begin
        done_c = cyc;
        check("done_busy", busy, 0);
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_c >= 0, 1);
    check("beat_count", got, beats);
    check("first_lat", first_v, 3);
    check("done_time", done_c, last_c + 1);
    if (!rnd) check("stream_gap", last_c - first_v, beats - 1);
    check("done_pulse", {done, busy, wt_valid}, 0);
    wt_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = word_of(i);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {wt_valid, busy, done, wt_b_vld, wt_last}, 0);
    check("rst_addr", {rom_addr_a, rom_addr_b}, 0);
    check("rst_data", wt_data_a | wt_data_b, 0);
    rst_n = 1'b1;

    // Async reset mid-fetch
    @(negedge clk);
    first_addr = AW'(0); num_words = AW'(20); start = 1'b1; wt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {wt_valid, busy, done, wt_b_vld, wt_last}, 0);
    check("mid_rst_addr", {rom_addr_a, rom_addr_b}, 0);
    check("mid_rst_data", wt_data_a | wt_data_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wt_ready = 1'b0;

    // Odd range; final pair re-reads word 14 on port B
    run_range(10, 5, 1'b0, -1);
    check("odd_addr", {rom_addr_a, rom_addr_b}, {AW'(14), AW'(14)});

    // Full ROM at full rate
    run_range(0, 76, 1'b0, -1);
    check("full_addr", {rom_addr_a, rom_addr_b}, {AW'(74), AW'(75)});

    // Random backpressure
    run_range(3, 8, 1'b1, -1);
    run_range(50, 7, 1'b1, -1);

    // Second start during fetch is ignored
    run_range(20, 6, 1'b0, 2);
    run_range(60, 1, 1'b0, -1);

    // Zero-length request
    @(negedge clk);
    first_addr = AW'(5); num_words = AW'(0); start = 1'b1; wt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_c1", {busy, done, wt_valid}, 3'b110);
    @(negedge clk);
    check("zero_c2", {busy, done, wt_valid}, 3'b000);
    @(negedge clk);
    check("zero_c3", {busy, done, wt_valid}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
